// File: rtl/rf_bank_stack_pkg.sv
// Shared definitions for the banked register-file stack: FSM encoding and default sizes.
package rf_bank_stack_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultNumLevels = 8;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } rf_state_e;

endpackage

// File: rtl/rf_bank_stack.sv
// Register file with one private bank per priority level and a set of registers shared by all
// levels; a level switch can optionally zero the target bank one register per cycle.
module rf_bank_stack
  import rf_bank_stack_pkg::*;
#(
  parameter int unsigned        DataWidth  = DefaultDataWidth,
  parameter int unsigned        NumRegs    = 32,
  parameter int unsigned        NumLevels  = DefaultNumLevels,
  parameter logic [NumRegs-1:0] SharedMask = NumRegs'('h4),
  parameter int unsigned        IndexWidth = $clog2(NumRegs),
  parameter int unsigned        LevelWidth = $clog2(NumLevels)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enterValid,
  input  logic [LevelWidth-1:0] enterLevel,
  input  logic                  enterClear,
  input  logic                  writeEn,
  input  logic [IndexWidth-1:0] writeAddr,
  input  logic [DataWidth-1:0]  writeData,
  input  logic [IndexWidth-1:0] readAddr1,
  input  logic [IndexWidth-1:0] readAddr2,
  output logic [DataWidth-1:0]  readData1,
  output logic [DataWidth-1:0]  readData2,
  output logic [LevelWidth-1:0] level,
  output logic                  busy
);

  localparam logic [IndexWidth-1:0] LastIdx = IndexWidth'(NumRegs - 1);

  rf_state_e                                            state_q;
  logic [LevelWidth-1:0]                                level_q;
  logic [IndexWidth-1:0]                                idx_q;
  logic [NumLevels-1:0][NumRegs-1:0][DataWidth-1:0]     bank_q;

  logic                  level_legal;
  logic                  write_ok;
  logic                  enter_ok;
  logic [LevelWidth-1:0] sel1;
  logic [LevelWidth-1:0] sel2;

  // Only non-power-of-two level counts can see an out-of-range target.
  if (NumLevels == (1 << LevelWidth)) begin : g_levels_pow2
    assign level_legal = 1'b1;
  end else begin : g_levels_npow2
    assign level_legal = ({1'b0, enterLevel} < (LevelWidth + 1)'(NumLevels));
  end

  assign write_ok = writeEn && (state_q == StIdle) && (writeAddr != '0);
  assign enter_ok = enterValid && (state_q == StIdle) && level_legal;

  assign sel1 = SharedMask[readAddr1] ? '0 : level_q;
  assign sel2 = SharedMask[readAddr2] ? '0 : level_q;

  always_comb begin
    readData1 = bank_q[sel1][readAddr1];
    if (reset || (readAddr1 == '0)) begin
      readData1 = '0;
    end else if (write_ok && (readAddr1 == writeAddr)) begin
      readData1 = writeData;
    end
  end

  always_comb begin
    readData2 = bank_q[sel2][readAddr2];
    if (reset || (readAddr2 == '0)) begin
      readData2 = '0;
    end else if (write_ok && (readAddr2 == writeAddr)) begin
      readData2 = writeData;
    end
  end

  assign level = level_q;
  assign busy  = (state_q == StClear);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      level_q <= '0;
      idx_q   <= '0;
      bank_q  <= '0;
    end else begin
      // Shared registers live in bank 0; the write lands in the level active before any switch.
      if (write_ok) begin
        if (SharedMask[writeAddr]) begin
          bank_q[0][writeAddr] <= writeData;
        end else begin
          bank_q[level_q][writeAddr] <= writeData;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (enter_ok) begin
            level_q <= enterLevel;
            if (enterClear) begin
              idx_q   <= IndexWidth'(1);
              state_q <= StClear;
            end
          end
        end
        StClear: begin
          if (!SharedMask[idx_q]) begin
            bank_q[level_q][idx_q] <= '0;
          end
          if (idx_q == LastIdx) begin
            state_q <= StIdle;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_bank_stack.sv
// Bench for rf_bank_stack: directed scenarios followed by random traffic against an array model.
module tb_rf_bank_stack;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned NL = 8;
  localparam int unsigned IW = 5;
  localparam int unsigned LW = 3;
  localparam logic [NR-1:0] Shared = 32'h4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enterValid;
  logic [LW-1:0] enterLevel;
  logic          enterClear;
  logic          writeEn;
  logic [IW-1:0] writeAddr;
  logic [DW-1:0] writeData;
  logic [IW-1:0] readAddr1;
  logic [IW-1:0] readAddr2;
  logic [DW-1:0] readData1;
  logic [DW-1:0] readData2;
  logic [LW-1:0] level;
  logic          busy;

  always #5 clk = ~clk;

  rf_bank_stack #(
    .DataWidth (DW),
    .NumRegs   (NR),
    .NumLevels (NL),
    .SharedMask(Shared)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .enterValid(enterValid),
    .enterLevel(enterLevel),
    .enterClear(enterClear),
    .writeEn   (writeEn),
    .writeAddr (writeAddr),
    .writeData (writeData),
    .readAddr1 (readAddr1),
    .readAddr2 (readAddr2),
    .readData1 (readData1),
    .readData2 (readData2),
    .level     (level),
    .busy      (busy)
  );

  // Reference model: architectural contents per level, shared registers kept in level 0.
  logic [DW-1:0] mem [NL][NR];
  int            lvl;
  int            busy_left;
  int            compared = 0;
  int            mismatched = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input int a);
    if (reset || a == 0) return '0;
    if (busy_left == 0 && writeEn && writeAddr != 0 && int'(writeAddr) == a) return writeData;
    return Shared[a] ? mem[0][a] : mem[lvl][a];
  endfunction

  task automatic check_read(input string tag, input int a, input logic [DW-1:0] obs);
    // Private registers of a bank being cleared are allowed to hold stale data.
    if (reset || busy_left == 0 || Shared[a] || a == 0) check(tag, obs, exp_read(a));
  endtask

  task automatic model_update();
    if (reset) begin
      for (int l = 0; l < NL; l++) for (int r = 0; r < NR; r++) mem[l][r] = '0;
      lvl = 0;
      busy_left = 0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (writeEn && writeAddr != 0) begin
        if (Shared[writeAddr]) mem[0][writeAddr] = writeData;
        else mem[lvl][writeAddr] = writeData;
      end
      if (enterValid && int'(enterLevel) < NL) begin
        lvl = int'(enterLevel);
        if (enterClear) begin
          for (int r = 1; r < NR; r++) if (!Shared[r]) mem[lvl][r] = '0;
          busy_left = NR - 1;
        end
      end
    end
  endtask

  task automatic step(input string tag);
    #3;
    check({tag, " level"}, DW'(level), DW'(lvl));
    check({tag, " busy"}, DW'(busy), DW'(busy_left > 0));
    check_read({tag, " rd1"}, int'(readAddr1), readData1);
    check_read({tag, " rd2"}, int'(readAddr2), readData2);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    writeEn = 1'b1;
    writeAddr = IW'(a);
    writeData = d;
    step("wr");
    writeEn = 1'b0;
  endtask

  task automatic enter(input int l, input logic c);
    enterValid = 1'b1;
    enterLevel = LW'(l);
    enterClear = c;
    step("enter");
    enterValid = 1'b0;
    enterClear = 1'b0;
  endtask

  task automatic peek1(input string tag, input int a, input logic [DW-1:0] exp);
    readAddr1 = IW'(a);
    #1;
    check(tag, readData1, exp);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    enterValid = 1'b0;
    enterLevel = '0;
    enterClear = 1'b0;
    writeEn = 1'b0;
    writeAddr = '0;
    writeData = '0;
    readAddr1 = 5'd5;
    readAddr2 = 5'd31;
    lvl = 0;
    busy_left = 0;
    for (int l = 0; l < NL; l++) for (int r = 0; r < NR; r++) mem[l][r] = '0;

    #1;
    peek1("rst_during", 2, '0);
    step("rst");
    step("rst");
    reset = 1'b0;
    step("post_rst");

    // Write-through and x0 hardwiring
    readAddr1 = 5'd7;
    writeEn = 1'b1;
    writeAddr = 5'd7;
    writeData = 32'h1234;
    #1;
    check("write_through", readData1, 32'h1234);
    step("wt");
    writeEn = 1'b0;
    wr(0, 32'hFFFF);
    peek1("x0_zero", 0, '0);

    // Private bank contents survive a non-clearing round trip
    wr(5, 32'hAAAA);
    enter(3, 1'b0);
    wr(5, 32'h5555);
    peek1("x5_lvl3", 5, 32'h5555);
    enter(0, 1'b0);
    peek1("x5_lvl0", 5, 32'hAAAA);

    // Shared x2 visible across levels
    enter(1, 1'b0);
    wr(2, 32'h1000);
    enter(4, 1'b0);
    peek1("x2_shared", 2, 32'h1000);
    check("level4", DW'(level), 32'd4);

    // Clearing switch into a populated bank
    enter(2, 1'b0);
    for (int i = 1; i < NR; i++) if (i != 2) wr(i, 32'h111 * i + 1);
    peek1("x9_filled", 9, 32'h111 * 9 + 1);
    enter(2, 1'b1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      readAddr1 = 5'd2;
      step("clr");
      cnt++;
    end
    check("busy_cycles", DW'(cnt), 32'd31);
    for (int i = 1; i < NR; i++) peek1("cleared", i, (i == 2) ? 32'h1000 : 32'h0);

    // Writes and switches ignored while busy, then reset mid-clear
    enter(5, 1'b1);
    writeEn = 1'b1;
    writeAddr = 5'd2;
    writeData = 32'hDEAD;
    enterValid = 1'b1;
    enterLevel = 3'd6;
    readAddr1 = 5'd2;
    for (int i = 0; i < 5; i++) step("busy_ign");
    writeEn = 1'b0;
    enterValid = 1'b0;
    check("busy_level", DW'(level), 32'd5);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      step("drain");
      cnt++;
    end
    peek1("x2_kept", 2, 32'h1000);
    wr(9, 32'h9999);
    enter(5, 1'b1);
    for (int i = 0; i < 9; i++) step("clr10");
    reset = 1'b1;
    step("rst_mid");
    reset = 1'b0;
    check("rst_busy", DW'(busy), 32'd0);
    check("rst_level", DW'(level), 32'd0);
    for (int i = 0; i < NR; i++) peek1("rst_zero", i, '0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      writeEn = $urandom_range(0, 1) == 1;
      writeAddr = IW'($urandom_range(0, NR - 1));
      writeData = $urandom;
      enterValid = ($urandom_range(0, 15) == 0);
      enterLevel = LW'($urandom_range(0, NL - 1));
      enterClear = $urandom_range(0, 1) == 1;
      readAddr1 = ($urandom_range(0, 3) == 0) ? writeAddr : IW'($urandom_range(0, NR - 1));
      readAddr2 = ($urandom_range(0, 7) == 0) ? 5'd2 : IW'($urandom_range(0, NR - 1));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rf_bank_stack.md
RF_BANK_STACK -- requirements
Module: rf_bank_stack

Interface
REQ-001 SHALL have parameter DataWidth, default 32, register data width.
REQ-002 SHALL have parameter NumRegs, default 32, architectural registers per level.
REQ-003 SHALL have parameter NumLevels, default 8, number of priority-level banks.
REQ-004 SHALL have parameter SharedMask, NumRegs bits, default 'h4 (x2/sp); bit i set means register i is one physical copy in bank 0, shared by all levels.
REQ-005 SHALL have derived parameters IndexWidth = $clog2(NumRegs) and LevelWidth = $clog2(NumLevels).
REQ-006 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port enterValid  in  1  one-cycle request to switch the active level.
REQ-009 SHALL have port enterLevel  in  LevelWidth  target level of the switch.
REQ-010 SHALL have port enterClear  in  1  when set with enterValid, zero the target bank's private registers.
REQ-011 SHALL have port writeEn  in  1  write strobe.
REQ-012 SHALL have port writeAddr / writeData  in  IndexWidth / DataWidth  write address / data.
REQ-013 SHALL have ports readAddr1, readAddr2  in  IndexWidth  read addresses.
REQ-014 SHALL have ports readData1, readData2  out  DataWidth  combinational read data.
REQ-015 SHALL have port level  out  LevelWidth  current active level.
REQ-016 SHALL have port busy  out  1  bank clear in progress; core stalls while high.

Function
REQ-017 Register 0 SHALL read as 0; writes to it SHALL be discarded.
REQ-018 An address with its SharedMask bit set SHALL access bank 0 regardless of level; other addresses SHALL access bank[level].
REQ-019 A write SHALL take effect at the clock edge when writeEn=1, busy=0 and writeAddr!=0.
REQ-020 Same-cycle write-through: if writeEn=1, busy=0, writeAddr!=0 and readAddrN==writeAddr, readDataN SHALL equal writeData.
REQ-021 FSM states SHALL be IDLE and CLEAR.
REQ-022 In IDLE, enterValid=1 with enterClear=0 SHALL set level=enterLevel at the next edge; FSM stays IDLE.
REQ-023 In IDLE, enterValid=1 with enterClear=1 SHALL set level=enterLevel, load the clear index with 1, and go to CLEAR at the next edge.
REQ-024 In CLEAR, each cycle SHALL zero bank[level][index] if SharedMask[index]=0 and no-op otherwise, then increment index.
REQ-025 After index NumRegs-1 is processed, CLEAR SHALL return to IDLE; busy SHALL stay high exactly NumRegs-1 cycles (31 at default).
REQ-026 busy SHALL be 1 iff state==CLEAR.
REQ-027 While busy=1, writeEn and enterValid SHALL be ignored.
REQ-028 While busy=1, reads of shared registers SHALL return valid data; reads of private registers SHALL return bank[level] contents, which may not yet be cleared.
REQ-029 A write in the same cycle as an accepted enterValid SHALL go to the old level; the level change SHALL take effect after that edge.
REQ-030 enterLevel >= NumLevels (non-power-of-two NumLevels) SHALL be ignored, with no state change.
REQ-031 A non-clearing switch back to a previously used level SHALL preserve that bank's contents.

Reset
REQ-032 reset SHALL zero all banks, set level=0 and state=IDLE, and drive busy=0.
REQ-033 reset asserted mid-CLEAR SHALL abort the clear; reset takes priority over all other inputs.
REQ-034 readData1 and readData2 SHALL be 0 during and immediately after reset for every address.

Structure
REQ-035 The FSM state enum SHALL be defined in the shared core package.
REQ-036 The DataWidth and NumLevels defaults SHALL be defined in the shared core package.
REQ-037 The module SHALL be flat, with no sub-modules; storage SHALL be a packed [NumLevels][NumRegs][DataWidth] array.

Verification
REQ-038 Write x5=0xAAAA at level 0, switch to level 3 without clear, write x5=0x5555, switch to level 0 -> read x5=0xAAAA.
REQ-039 Write x2=0x1000 at level 1, switch to level 4 -> read x2=0x1000 (shared).
REQ-040 Fill level 2 with nonzero values, then enterValid with enterClear=1 to level 2 -> busy high 31 cycles, then all private registers read 0 and x2 keeps its value.
REQ-041 Write x7=0x1234 with readAddr1=7 in the same cycle -> readData1=0x1234; write x0=0xFFFF -> x0 reads 0.
REQ-042 Assert writeEn and enterValid while busy -> no register or level change; assert reset at cycle 10 of a clear -> busy=0 and all registers 0 next cycle.
